// File: rtl/tt_arith_pkg.sv
// Shared definitions for the arithmetic/accumulator block.
// Holds the operation-mode encodings used by the top and by its users.
// No logic here: constants only.
package tt_arith_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;  // result = a + b
  localparam logic [1:0] MODE_SUB = 2'b01;  // result = a - b
  localparam logic [1:0] MODE_ACC = 2'b10;  // acc = acc + a
  localparam logic [1:0] MODE_DEC = 2'b11;  // acc = acc - a

endpackage : tt_arith_pkg

// File: rtl/tt_clk_div.sv
// Heartbeat divider: square wave toggling every 2^DIV_LOG2 clocks.
// Latency: first toggle 2^DIV_LOG2 clocks after reset release.
// Backpressure: none, free-running.
module tt_clk_div #(
  parameter int DIV_LOG2 = 0
) (
  input  logic clk,
  input  logic rst,
  output logic tick_out
);

  // Keep at least one counter bit so DIV_LOG2=0 still has a legal vector.
  localparam int CW = (DIV_LOG2 < 1) ? 1 : DIV_LOG2;
  localparam logic [CW-1:0] TERM = CW'((1 << DIV_LOG2) - 1);

  logic [CW-1:0] count;

  // Count up to TERM, then wrap and flip the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      tick_out <= 1'b0;
    end else if (count == TERM) begin
      count    <= '0;
      tick_out <= ~tick_out;
    end else begin
      count    <= count + CW'(1);
    end
  end

endmodule : tt_clk_div

// File: rtl/tt_arith_accum.sv
// Registered add/sub unit with accumulator, saturation, overflow flags and heartbeat.
// Latency: 1 clock from accept to result; full throughput while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds steady.
module tt_arith_accum #(
  parameter int DIV_LOG2 = 0,
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc,
  output logic             heartbeat
);

  import tt_arith_pkg::*;

  logic             accept;
  logic             consume;
  logic             is_acc;
  logic             is_sub;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   raw;
  logic             op_ovf;
  logic [WIDTH-1:0] op_res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Operand select and WIDTH+1 bit arithmetic; top bit is carry (add) or borrow (sub).
  always_comb begin
    is_acc   = (mode == MODE_ACC) || (mode == MODE_DEC);
    is_sub   = (mode == MODE_SUB) || (mode == MODE_DEC);
    // A same-cycle clear makes the accumulate op start from zero.
    acc_base = clear ? '0 : acc;
    lhs      = is_acc ? acc_base : a;
    rhs      = is_acc ? a : b;
    raw      = is_sub ? ({1'b0, lhs} - {1'b0, rhs}) : ({1'b0, lhs} + {1'b0, rhs});
    op_ovf   = raw[WIDTH];
    op_res   = raw[WIDTH-1:0];
    if (SATURATE && op_ovf) begin
      op_res = is_sub ? '0 : '1;
    end
  end

  // Output register: load on accept, drop valid on a consume with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= op_res;
      ovf       <= op_ovf;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator and sticky flag; clear only touches these, never the pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept && is_acc) begin
        acc <= op_res;
      end else if (clear) begin
        acc <= '0;
      end
      if (accept) begin
        ovf_sticky <= (clear ? 1'b0 : ovf_sticky) | op_ovf;
      end else if (clear) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  tt_clk_div #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .tick_out (heartbeat)
  );

endmodule : tt_arith_accum

// File: tb/tb_tt_arith_accum.sv
// Bench for tt_arith_accum: two instances share stimulus.
// u0: SATURATE=1, DIV_LOG2=0.  u1: SATURATE=0, DIV_LOG2=2.
// Directed scenarios plus a randomized run against an integer reference model.
module tb_tt_arith_accum;
  import tt_arith_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] mode = MODE_ADD;
  logic       clear = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, ovf0, stk0, hb0;
  logic [7:0] result0, acc0;
  logic       in_ready1, out_valid1, ovf1, stk1, hb1;
  logic [7:0] result1, acc1;

  int n_pass  = 0;
  int n_total = 0;
  int hb_edges;

  // Reference model state, index 0 = saturating instance, 1 = wrapping instance.
  int m_acc[2];
  int m_res[2];
  bit m_ovf[2];
  bit m_stk[2];
  bit m_ov[2];

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) hb_edges <= 0;
    else     hb_edges <= hb_edges + 1;
  end

  tt_arith_accum #(.DIV_LOG2(0), .WIDTH(8), .SATURATE(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .mode(mode), .clear(clear), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .ovf(ovf0), .ovf_sticky(stk0), .acc(acc0), .heartbeat(hb0));

  tt_arith_accum #(.DIV_LOG2(2), .WIDTH(8), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .mode(mode), .clear(clear), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .ovf(ovf1), .ovf_sticky(stk1), .acc(acc1), .heartbeat(hb1));

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_res[i] = 0; m_ovf[i] = 0; m_stk[i] = 0; m_ov[i] = 0;
    end
  endtask

  // Apply one rising edge worth of behaviour, using the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit sat  = (i == 0);
      bit take = in_valid && (!m_ov[i] || out_ready);
      bit accm = (mode == MODE_ACC) || (mode == MODE_DEC);
      bit subm = (mode == MODE_SUB) || (mode == MODE_DEC);
      int l, r, v;
      bit o;
      if (take) begin
        l = accm ? (clear ? 0 : m_acc[i]) : int'(a);
        r = accm ? int'(a) : int'(b);
        if (subm) begin
          o = (l < r);
          v = l - r;
          if (o) v = sat ? 0 : v + 256;
        end else begin
          v = l + r;
          o = (v > 255);
          if (o) v = sat ? 255 : v - 256;
        end
        m_res[i] = v;
        m_ovf[i] = o;
        m_ov[i]  = 1;
        m_stk[i] = (clear ? 1'b0 : m_stk[i]) | o;
        if (accm)       m_acc[i] = v;
        else if (clear) m_acc[i] = 0;
      end else begin
        if (m_ov[i] && out_ready) m_ov[i] = 0;
        if (clear) begin
          m_acc[i] = 0;
          m_stk[i] = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [1:0] im, input logic ic, input logic ordy);
    in_valid  = v;
    a         = ia;
    b         = ib;
    mode      = im;
    clear     = ic;
    out_ready = ordy;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, MODE_ADD, 0, 1);
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_valid0, result0, ovf0, stk0, acc0, hb0} !== 20'h0 ||
        {out_valid1, result1, ovf1, stk1, acc1, hb1} !== 20'h0)
      $display("FAIL reset_state u0=%h u1=%h want 0", {out_valid0, result0, ovf0, stk0, acc0, hb0},
               {out_valid1, result1, ovf1, stk1, acc1, hb1});
    else n_pass++;
    n_total++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL reset_in_ready got %b%b want 11", in_ready0, in_ready1);
    else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_add_sat();
    drive(1, 200, 100, MODE_ADD, 0, 1);
    clock();
    n_total++;
    if (result0 !== 8'd255 || ovf0 !== 1'b1 || stk0 !== 1'b1 || out_valid0 !== 1'b1)
      $display("FAIL add_sat u0 res=%0d ovf=%b stk=%b vld=%b want 255 1 1 1", result0, ovf0, stk0, out_valid0);
    else n_pass++;
    n_total++;
    if (result1 !== 8'd44 || ovf1 !== 1'b1)
      $display("FAIL add_wrap u1 res=%0d ovf=%b want 44 1", result1, ovf1);
    else n_pass++;
    drive(1, 3, 4, MODE_ADD, 0, 1);
    clock();
    n_total++;
    if (result0 !== 8'd7 || ovf0 !== 1'b0 || stk0 !== 1'b1)
      $display("FAIL add_small u0 res=%0d ovf=%b stk=%b want 7 0 1", result0, ovf0, stk0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1, 5, 10, MODE_SUB, 0, 1);
    clock();
    n_total++;
    if (result1 !== 8'd251 || ovf1 !== 1'b1)
      $display("FAIL sub_wrap u1 res=%0d ovf=%b want 251 1", result1, ovf1);
    else n_pass++;
    n_total++;
    if (result0 !== 8'd0 || ovf0 !== 1'b1)
      $display("FAIL sub_sat u0 res=%0d ovf=%b want 0 1", result0, ovf0);
    else n_pass++;
    drive(1, 255, 1, MODE_ADD, 0, 1);
    clock();
    n_total++;
    if (result1 !== 8'd0 || ovf1 !== 1'b1 || result0 !== 8'd255)
      $display("FAIL add_255_1 u1 res=%0d ovf=%b u0 res=%0d want 0 1 255", result1, ovf1, result0);
    else n_pass++;
  endtask

  task automatic test_acc();
    int exp0[3] = '{100, 200, 255};
    int exp1[3] = '{100, 200, 44};
    drive(0, 0, 0, MODE_ADD, 1, 1);
    clock();
    n_total++;
    if (stk0 !== 1'b0 || acc0 !== 8'd0)
      $display("FAIL clear_idle u0 stk=%b acc=%0d want 0 0", stk0, acc0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(1, 100, 0, MODE_ACC, 0, 1);
      clock();
      n_total++;
      if (int'(acc0) != exp0[k] || int'(result0) != exp0[k] || int'(acc1) != exp1[k])
        $display("FAIL acc_step%0d u0 acc=%0d res=%0d u1 acc=%0d want %0d %0d %0d",
                 k, acc0, result0, acc1, exp0[k], exp0[k], exp1[k]);
      else n_pass++;
    end
    drive(1, 7, 0, MODE_ACC, 1, 1);
    clock();
    n_total++;
    if (acc0 !== 8'd7 || result0 !== 8'd7 || stk0 !== 1'b0 || acc1 !== 8'd7 || stk1 !== 1'b0)
      $display("FAIL clear_with_acc u0 acc=%0d res=%0d stk=%b u1 acc=%0d stk=%b want 7 7 0 7 0",
               acc0, result0, stk0, acc1, stk1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(1, 1, 1, MODE_ADD, 0, 1);
    clock();
    drive(1, 3, 0, MODE_DEC, 0, 0);
    n_total++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0)
      $display("FAIL stall_in_ready got %b%b want 00", in_ready0, in_ready1);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      clock();
      n_total++;
      if (result0 !== 8'd2 || out_valid0 !== 1'b1 || acc0 !== 8'd7 || result1 !== 8'd2 || acc1 !== 8'd7)
        $display("FAIL stall_hold%0d u0 res=%0d vld=%b acc=%0d u1 res=%0d acc=%0d want 2 1 7 2 7",
                 k, result0, out_valid0, acc0, result1, acc1);
      else n_pass++;
    end
    drive(1, 3, 0, MODE_DEC, 0, 1);
    n_total++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL release_in_ready got %b%b want 11", in_ready0, in_ready1);
    else n_pass++;
    clock();
    n_total++;
    if (acc0 !== 8'd4 || result0 !== 8'd4 || ovf0 !== 1'b0 || out_valid0 !== 1'b1)
      $display("FAIL queued_dec u0 acc=%0d res=%0d ovf=%b vld=%b want 4 4 0 1", acc0, result0, ovf0, out_valid0);
    else n_pass++;
    drive(0, 0, 0, MODE_ADD, 0, 1);
    clock();
    n_total++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0)
      $display("FAIL drain_valid got %b%b want 00", out_valid0, out_valid1);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1, 9, 9, MODE_ADD, 0, 1);
    clock();
    drive(0, 0, 0, MODE_ADD, 0, 0);
    clock();
    n_total++;
    if (out_valid0 !== 1'b1 || result0 !== 8'd18)
      $display("FAIL prestall u0 vld=%b res=%0d want 1 18", out_valid0, result0);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid0, result0, acc0, hb0} !== 18'h0 || {out_valid1, result1, acc1, hb1} !== 18'h0)
      $display("FAIL async_reset u0=%h u1=%h want 0", {out_valid0, result0, acc0, hb0},
               {out_valid1, result1, acc1, hb1});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, MODE_ADD, 0, 1);
  endtask

  task automatic test_heartbeat();
    for (int k = 0; k < 20; k++) begin
      clock();
      n_total++;
      if (hb0 !== hb_edges[0] || hb1 !== hb_edges[2])
        $display("FAIL heartbeat edge%0d got %b%b want %b%b", hb_edges, hb0, hb1, hb_edges[0], hb_edges[2]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 1) == 1) ? 255 : 0) : 8'($urandom);
      rb = 8'($urandom);
      drive($urandom_range(0, 3) != 0, ra, rb, 2'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7);
      n_total++;
      if (in_ready0 !== (!m_ov[0] || out_ready) || in_ready1 !== (!m_ov[1] || out_ready))
        $display("FAIL rnd_in_ready%0d got %b%b want %b%b", k, in_ready0, in_ready1,
                 !m_ov[0] || out_ready, !m_ov[1] || out_ready);
      else n_pass++;
      clock();
      n_total++;
      if (int'(result0) != m_res[0] || ovf0 !== m_ovf[0] || stk0 !== m_stk[0] ||
          out_valid0 !== m_ov[0] || int'(acc0) != m_acc[0])
        $display("FAIL rnd_u0_%0d res=%0d ovf=%b stk=%b vld=%b acc=%0d want %0d %b %b %b %0d", k,
                 result0, ovf0, stk0, out_valid0, acc0, m_res[0], m_ovf[0], m_stk[0], m_ov[0], m_acc[0]);
      else n_pass++;
      n_total++;
      if (int'(result1) != m_res[1] || ovf1 !== m_ovf[1] || stk1 !== m_stk[1] ||
          out_valid1 !== m_ov[1] || int'(acc1) != m_acc[1])
        $display("FAIL rnd_u1_%0d res=%0d ovf=%b stk=%b vld=%b acc=%0d want %0d %b %b %b %0d", k,
                 result1, ovf1, stk1, out_valid1, acc1, m_res[1], m_ovf[1], m_stk[1], m_ov[1], m_acc[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_wrap();
    test_acc();
    test_backpressure();
    test_async_reset();
    test_heartbeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tt_arith_accum

// File: doc/tt_arith_accum.md
Name: tt_arith_accum

Overview:
- Parametrised successor to the registered 6-bit adder and clock-toggle block.
- Registered arithmetic unit: add or subtract two operands, or accumulate/decumulate one operand into an internal register.
- Options: unsigned saturation, overflow flags, valid/ready handshake with backpressure, and a parametrised heartbeat divider.
- Sits between the top-level pad wrapper and output pins; operands come from dedicated/bidirectional inputs.

Parameters:
- WIDTH, 8, operand/result/accumulator width in bits (>=2).
- SATURATE, 1, 1 = clamp unsigned results on overflow/underflow; 0 = modulo-2^WIDTH wrap.
- DIV_LOG2, 0, heartbeat toggles every 2^DIV_LOG2 clocks (period 2^(DIV_LOG2+1) clocks).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored in accumulate modes).
- mode  input  2  00 ADD a+b; 01 SUB a-b; 10 ACC acc+a; 11 DEC acc-a.
- clear  input  1  synchronous clear of accumulator and sticky flag.
- out_valid  output  1  result register holds unconsumed result.
- out_ready  input  1  downstream consumes result.
- result  output  WIDTH  registered result.
- ovf  output  1  carry-out (add) or borrow (sub) of the current result.
- ovf_sticky  output  1  OR of all ovf since reset/clear.
- acc  output  WIDTH  current accumulator value.
- heartbeat  output  1  divided-clock square wave.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job): result=0, ovf=0, ovf_sticky=0, out_valid=0, acc=0, heartbeat=0, divider count=0.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept: result/ovf registered next rising edge; out_valid=1. Latency 1 clock. Full throughput when out_ready held high.
- Consume = out_valid && out_ready. Consume with no accept clears out_valid. Simultaneous consume and accept reloads result; out_valid stays 1.
- Stall: out_valid && !out_ready holds result, ovf and out_valid stable; in_ready=0.
- Arithmetic is WIDTH+1 bit unsigned.
  - ADD/ACC: ovf = bit WIDTH of sum. If SATURATE, result = all-ones when ovf.
  - SUB/DEC: ovf = borrow (minuend < subtrahend). If SATURATE, result = 0 when ovf.
  - If SATURATE=0, result = low WIDTH bits.
- ACC/DEC: on accept, acc <= clamped/wrapped result (same value as result). ADD/SUB never modify acc.
- clear:
  - acc <= 0 and ovf_sticky <= 0.
  - clear coincident with an ACC/DEC accept: the operation uses acc=0 as its operand, and acc/result take that new value. ovf_sticky takes that op's ovf.
  - clear does not affect result/out_valid of a pending output.
- ovf_sticky |= ovf on every accept.
- Heartbeat: free-running counter of max(DIV_LOG2,1) bits. heartbeat toggles when count reaches 2^DIV_LOG2-1, then count wraps to 0. Independent of handshake.
- Mode or operands changing while not accepted have no effect. in_valid dropping mid-stall is legal.
- Reset mid-operation discards any pending result immediately.

Decomposition:
- Package tt_arith_pkg: mode localparams MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_DEC=2'b11.
- One sub-module tt_clk_div (param DIV_LOG2; ports clk, rst, tick_out) implements the heartbeat. Arithmetic, handshake and accumulator stay in the top.

Test Plan:
- WIDTH=8, SATURATE=1, out_ready=1: ADD a=200 b=100 -> next cycle result=255, ovf=1, ovf_sticky=1. Then ADD a=3 b=4 -> result=7, ovf=0, ovf_sticky remains 1.
- SATURATE=0: SUB a=5 b=10 -> result=251, ovf=1. ADD a=255 b=1 -> result=0, ovf=1.
- ACC sequence a=100,100,100 (SATURATE=1) -> acc 100, 200, 255. Then clear together with ACC a=7 -> acc=7, result=7, ovf_sticky=0.
- Backpressure: accept ADD 1+1, hold out_ready=0 for 3 cycles -> result=2 stable, in_ready=0, a DEC request is not applied. Raise out_ready -> in_ready=1 same cycle, queued op accepted.
- Assert rst asynchronously mid-stall (between edges) -> out_valid, result, acc, heartbeat all 0 immediately.
- DIV_LOG2=0 -> heartbeat toggles every clock (period 2). DIV_LOG2=2 -> toggles every 4 clocks (period 8) from reset release.
